svga_timing_gen: RTL

- Video timing generator clocked by the ~40 MHz pixel clock from the 27 MHz PLL stage; first consumer of that clock.
- Produces 800x600@60 (VESA, 40 MHz nominal) hsync, vsync, data-enable and pixel coordinates.
- Feeds the pixel source and the video output/serialiser stage.
- All timing is parameterised, so the same block serves other modes if the PLL divider set changes.

---
 rtl/svga_timing_pkg.sv | 34 +++
 rtl/timing_axis_counter.sv | 31 +++
 rtl/svga_timing_gen.sv | 90 +++++++++
 3 files changed

// File: rtl/svga_timing_pkg.sv
// Shared constants for the SVGA timing generator: 800x600@60 defaults,
// fixed counter widths and the registered output bundle.
package svga_timing_pkg;

    localparam int H_W = 11;
    localparam int V_W = 10;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    typedef struct packed {
        logic           hsync;
        logic           vsync;
        logic           de;
        logic           line_start;
        logic           frame_start;
        logic [H_W-1:0] x;
        logic [V_W-1:0] y;
    } tg_out_t;

endpackage

// File: rtl/timing_axis_counter.sv
// Wrapping 0..TOTAL-1 counter; wrap_o flags the last count so the caller
// can carry into the next axis.
module timing_axis_counter #(
    parameter int W     = 11,
    parameter int TOTAL = 1056
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = (cnt_q == LAST);

endmodule

// File: rtl/svga_timing_gen.sv
// Parameterised video timing generator: h/v counters, sync/DE decode and a
// single register stage so every output is aligned to the same counter state.
module svga_timing_gen
    import svga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [H_W-1:0] x,
    output logic [V_W-1:0] y,
    output logic           line_start,
    output logic           frame_start
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [H_W-1:0] H_VIS  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_VIS  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam tg_out_t OUT_RST = {~HS_POL, ~VS_POL, 3'b000, H_W'(0), V_W'(0)};

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           h_wrap;
    logic           unused_v_wrap;

    timing_axis_counter #(.W(H_W), .TOTAL(H_TOTAL)) u_h_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (en),
        .cnt_o  (h_cnt),
        .wrap_o (h_wrap)
    );

    // Lines advance only on the enabled cycle that retires the last pixel.
    timing_axis_counter #(.W(V_W), .TOTAL(V_TOTAL)) u_v_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (en && h_wrap),
        .cnt_o  (v_cnt),
        .wrap_o (unused_v_wrap)
    );

    tg_out_t out_d, out_q;

    always_comb begin
        out_d             = out_q;
        out_d.hsync       = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
        out_d.vsync       = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
        out_d.de          = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        out_d.line_start  = (h_cnt == '0);
        out_d.frame_start = (h_cnt == '0) && (v_cnt == '0);
        out_d.x           = h_cnt;
        out_d.y           = v_cnt;
    end

    // Stalls freeze pulses too; the consumer qualifies them with en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  out_q <= OUT_RST;
        else if (en) out_q <= out_d;
    end

    assign hsync       = out_q.hsync;
    assign vsync       = out_q.vsync;
    assign de          = out_q.de;
    assign line_start  = out_q.line_start;
    assign frame_start = out_q.frame_start;
    assign x           = out_q.x;
    assign y           = out_q.y;

endmodule
